ipml_fifo_fwft_rd_adapter: RTL

//  - Read-side adapter placed directly downstream of the L_FIFO read port, in the rd_clk domain.
//  - Converts the FIFO's standard read interface (rd_en, then data after a fixed latency) into a

---
 rtl/ipml_fifo_fwft_rd_adapter.sv | 114 +++++++++++
 1 files changed

// File: rtl/ipml_fifo_fwft_rd_adapter.sv
// Read-side adapter: turns the L_FIFO read port (rd_en, data after a fixed latency) into a
// first-word-fall-through valid/ready stream. Define FWFT_LEVEL_EN to add the buf_level output.
module ipml_fifo_fwft_rd_adapter #(
    parameter int c_DATA_WIDTH = 32,
    parameter int c_RD_LATENCY = 1
) (
    input  logic                    rd_clk,
    input  logic                    rd_rst,
    input  logic [c_DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                    fifo_rd_empty,
    output logic                    fifo_rd_en,
    output logic                    fifo_rd_oce,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [c_DATA_WIDTH-1:0] m_data
`ifdef FWFT_LEVEL_EN
    ,
    output logic [$clog2(c_RD_LATENCY+2)-1:0] buf_level
`endif
);

    localparam int c_BUF_DEPTH = c_RD_LATENCY + 1;
    localparam int c_CW        = $clog2(c_BUF_DEPTH + 1);
    localparam int c_PW        = $clog2(c_BUF_DEPTH);
    localparam int c_SW        = c_CW + 2;
    localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(c_BUF_DEPTH - 1);

    logic [c_RD_LATENCY-1:0] r_issue;
    logic [c_CW-1:0]         r_count;
    logic [c_PW-1:0]         r_wptr;
    logic [c_PW-1:0]         r_rptr;
    logic                    r_valid;
    logic [c_DATA_WIDTH-1:0] r_buf [c_BUF_DEPTH];

    logic            w_pop;
    logic            w_arrive;
    logic [c_SW-1:0] w_inflight;
    logic [c_SW-1:0] w_credit_used;
    logic [c_CW-1:0] w_count_nxt;

    function automatic logic [c_SW-1:0] f_popcount(input logic [c_RD_LATENCY-1:0] v);
        logic [c_SW-1:0] n;
        n = '0;
        for (int i = 0; i < c_RD_LATENCY; i++) begin
            n = n + c_SW'(v[i]);
        end
        return n;
    endfunction

    // Depth is usually not a power of two, so the wrap is explicit.
    function automatic logic [c_PW-1:0] f_ptr_inc(input logic [c_PW-1:0] p);
        logic [c_PW-1:0] q;
        if (p == c_PTR_LAST) begin
            q = '0;
        end else begin
            q = p + c_PW'(1'b1);
        end
        return q;
    endfunction

    // Credit check counts this cycle's pop so a full buffer can keep issuing while draining.
    always_comb begin
        w_pop         = r_valid & m_ready;
        w_arrive      = r_issue[c_RD_LATENCY-1];
        w_inflight    = f_popcount(r_issue);
        w_credit_used = c_SW'(r_count) + w_inflight - c_SW'(w_pop);
        w_count_nxt   = r_count + c_CW'(w_arrive) - c_CW'(w_pop);
        if (rd_rst || fifo_rd_empty) begin
            fifo_rd_en = 1'b0;
        end else begin
            fifo_rd_en = (w_credit_used < c_SW'(c_BUF_DEPTH));
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_issue <= '0;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_issue <= (r_issue << 1'b1) | c_RD_LATENCY'(fifo_rd_en);
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            if (w_arrive) begin
                r_wptr <= f_ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_ptr_inc(r_rptr);
            end
        end
    end

    // Skid storage; cleared on reset so m_data reads zero until the first word lands.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            for (int i = 0; i < c_BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_arrive) begin
            r_buf[r_wptr] <= fifo_rd_data;
        end
    end

    assign fifo_rd_oce = 1'b1;
    assign m_valid     = r_valid;
    assign m_data      = r_buf[r_rptr];

`ifdef FWFT_LEVEL_EN
    assign buf_level = r_count;
`endif

endmodule
